// File: rtl/cmd_sched.sv
// cmd_sched: round-robin scheduler serializing {start, addr, op byte} frames onto tx with an opcode-dependent idle guard.
// Define CMD_SCHED_PARITY_EN to append an even-parity bit after the opcode byte.
module cmd_sched #(
    parameter int NREQ        = 4,
    parameter int GUARD_SHORT = 32,
    parameter int GUARD_LONG  = 128
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] addr_bus,
    input  logic [NREQ*3-1:0] op_bus,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic              tx
);
    localparam int PW = $clog2(NREQ);
    localparam int GM = GUARD_LONG > GUARD_SHORT ? GUARD_LONG : GUARD_SHORT;
    localparam int CW = $clog2((GM > 9 ? GM : 9) + 1);
`ifdef CMD_SCHED_PARITY_EN
    localparam int OP_LAST = 8;
`else
    localparam int OP_LAST = 7;
`endif

    typedef enum logic [1:0] {IDLE, ADDR, OP, GUARD} state_t;

    state_t          state, ns;
    logic [CW-1:0]   cnt, ncnt, glast;
    logic [PW-1:0]   ptr, win, nwin, nptr;
    logic [PW:0]     sum, nxt;
    logic [2*NREQ-1:0] rot;
    logic            found, obit, ntx;
    logic [7:0]      addr_q, op_byte;
    logic [2:0]      op_q;

    // state/cnt describe what tx is showing in the current cycle; ADDR cnt 0 is the start bit
    assign busy    = state != IDLE;
    assign gnt     = (state == ADDR && cnt == '0) ? NREQ'(1) << win : '0;
    assign done    = state == GUARD && cnt == glast;
    assign op_byte = {4'b0, op_q, 1'b0};

    always_comb begin
        rot   = {req, req} >> ptr;
        found = 1'b0;
        nwin  = ptr;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (PW+1)'(k);
                nwin  = sum >= (PW+1)'(NREQ) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
            end
        end
        nxt  = {1'b0, nwin} + (PW+1)'(1);
        nptr = nxt == (PW+1)'(NREQ) ? '0 : PW'(nxt);
    end

    always_comb begin
        ns    = state;
        ncnt  = cnt + CW'(1);
        glast = (op_q == 3'd2 || op_q == 3'd3) ? CW'(GUARD_LONG - 1) : CW'(GUARD_SHORT - 1);
        case (state)
            IDLE: begin
                ncnt = '0;
                ns   = |req ? ADDR : IDLE;
            end
            ADDR: if (cnt == CW'(8)) begin
                ns   = OP;
                ncnt = '0;
            end
            OP: if (cnt == CW'(OP_LAST)) begin
                ns   = GUARD;
                ncnt = '0;
            end
            default: if (cnt == glast) begin
                ns   = IDLE;
                ncnt = '0;
            end
        endcase
`ifdef CMD_SCHED_PARITY_EN
        obit = ncnt[3] ? ^{addr_q, op_q} : op_byte[ncnt[2:0]];
`else
        obit = op_byte[ncnt[2:0]];
`endif
        ntx = ns == ADDR ? (ncnt == '0 ? 1'b0 : addr_q[3'(ncnt - CW'(1))]) :
              ns == OP   ? obit : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            win    <= '0;
            addr_q <= '0;
            op_q   <= '0;
            tx     <= 1'b1;
        end else begin
            state <= ns;
            cnt   <= ncnt;
            tx    <= ntx;
            if (state == IDLE && |req) begin
                win    <= nwin;
                ptr    <= nptr;
                addr_q <= addr_bus[8*nwin +: 8];
                op_q   <= op_bus[3*nwin +: 3];
            end
        end
    end
endmodule

// File: tb/tb_cmd_sched.sv
// tb_cmd_sched: scoreboard bench; stimulus queues expected frames, a monitor checks each granted frame on tx.
module tb_cmd_sched;
`ifdef CMD_SCHED_PARITY_EN
    localparam int FLEN = 18;
`else
    localparam int FLEN = 17;
`endif
    localparam int GS = 32;
    localparam int GL = 128;

    typedef struct {
        logic [3:0]  g;
        logic [17:0] f;
        int          guard;
        int          gap;
        int          abort;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRst;
    logic [3:0]  req;
    logic [31:0] addr_bus;
    logic [11:0] op_bus;
    logic [3:0]  gnt;
    logic        busy, done, tx;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    cmd_sched #(.NREQ(4), .GUARD_SHORT(GS), .GUARD_LONG(GL)) dut (
        .clk(clk), .nRst(nRst), .req(req), .addr_bus(addr_bus), .op_bus(op_bus),
        .gnt(gnt), .busy(busy), .done(done), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [17:0] mk(input logic [7:0] a, input logic [2:0] o);
        logic [17:0] f;
        f = {1'b0, 4'b0, o, 1'b0, a, 1'b0};
`ifdef CMD_SCHED_PARITY_EN
        f[17] = ^{a, o};
`endif
        return f;
    endfunction

    task automatic setr(input int i, input logic [7:0] a, input logic [2:0] o);
        addr_bus[8*i +: 8] = a;
        op_bus[3*i +: 3]   = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt();
        int k = 0;
        @(negedge clk);
        while (gnt == 0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (gnt == 0) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    // monitor: each grant pops one expected frame and follows it until busy drops
    initial begin
        exp_t        e;
        logic [17:0] frm;
        int n, guard, done_at, bad, k, last_start;
        last_start = 0;
        forever begin
            @(negedge clk);
            if (nRst && gnt != 0) begin
                if (sb.size() == 0) check("unexpected_gnt", int'(gnt), 0);
                else begin
                    e = sb.pop_front();
                    check("gnt", int'(gnt), int'(e.g));
                    if (e.gap != 0) check("start_gap", cyc - last_start, e.gap);
                    last_start = cyc;
                    frm = '0;
                    frm[0] = tx;
                    n = 1; guard = 0; done_at = -1; bad = 0; k = 0;
                    while (k < 400) begin
                        @(negedge clk);
                        k++;
                        if (!busy) break;
                        if (gnt != 0) bad++;
                        if (n < FLEN) begin
                            if (done) bad++;
                            frm[n] = tx;
                            n++;
                        end else begin
                            guard++;
                            if (!tx) bad++;
                            if (done) done_at = guard;
                        end
                    end
                    if (k >= 400) check("busy_timeout", k, 0);
                    if (e.abort != 0) begin
                        check("abort_len", n, e.abort);
                        check("abort_bits", int'(frm), int'(e.f & ((18'd1 << e.abort) - 18'd1)));
                    end else begin
                        check("frame", int'(frm), int'(e.f));
                        check("frame_len", n, FLEN);
                        check("guard_len", guard, e.guard);
                        check("done_pos", done_at, e.guard);
                        check("stray_outputs", bad, 0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; req = '0; addr_bus = '0; op_bus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_gnt", int'(gnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        tick();
        nRst = 1'b1;

        // single request, operands changed after grant must not matter
        setr(0, 8'h5A, 3'd5);
        sb.push_back('{4'b0001, {1'b0, 8'h0A, 8'h5A, 1'b0}, GS, 0, 0});
        req = 4'b0001;
        wait_gnt();
        tick();
        req = '0;
        tick();
        setr(0, 8'h00, 3'd0);
        wait_idle();

        // all four requesting from pointer 0
        tick();
        nRst = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        setr(0, 8'h11, 3'd0);
        setr(1, 8'h22, 3'd1);
        setr(2, 8'h33, 3'd4);
        setr(3, 8'h44, 3'd7);
        sb.push_back('{4'b0001, mk(8'h11, 3'd0), GS, 0, 0});
        sb.push_back('{4'b0010, mk(8'h22, 3'd1), GS, FLEN + GS + 1, 0});
        sb.push_back('{4'b0100, mk(8'h33, 3'd4), GS, FLEN + GS + 1, 0});
        sb.push_back('{4'b1000, mk(8'h44, 3'd7), GS, FLEN + GS + 1, 0});
        sb.push_back('{4'b0001, mk(8'h11, 3'd0), GS, FLEN + GS + 1, 0});
        req = 4'b1111;
        repeat (5) wait_gnt();
        tick();
        req = '0;
        wait_idle();

        // long-guard opcodes, pointer now at 1 so requester 2 wins before 3
        setr(2, 8'hFF, 3'd3);
        setr(3, 8'h80, 3'd2);
        sb.push_back('{4'b0100, mk(8'hFF, 3'd3), GL, 0, 0});
        sb.push_back('{4'b1000, mk(8'h80, 3'd2), GL, FLEN + GL + 1, 0});
        tick();
        req = 4'b1100;
        wait_gnt();
        tick();
        req = 4'b1000;
        wait_gnt();
        tick();
        req = '0;
        wait_idle();

        // reset during address bit 5
        setr(0, 8'hC3, 3'd6);
        sb.push_back('{4'b0001, mk(8'hC3, 3'd6), GS, 0, 7});
        tick();
        req = 4'b0001;
        wait_gnt();
        tick();
        req = '0;
        repeat (5) tick();
        nRst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", int'(tx), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_gnt", int'(gnt), 0);
        tick();
        nRst = 1'b1;

        // pointer must be back at 0: requester 0 beats requester 1
        setr(0, 8'h01, 3'd1);
        setr(1, 8'h3C, 3'd1);
        sb.push_back('{4'b0001, mk(8'h01, 3'd1), GS, 0, 0});
        sb.push_back('{4'b0010, mk(8'h3C, 3'd1), GS, FLEN + GS + 1, 0});
        req = 4'b0011;
        wait_gnt();
        tick();
        req = 4'b0010;
        wait_gnt();
        tick();
        req = '0;
        wait_idle();

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
